// File: rtl/uart_mc_monitor.sv
// Multi-channel UART receive monitor: per-channel sync, frame FSM and FIFO, round-robin onto one stream.
// Latency: stop-bit sample in cycle N gives m_valid_o at N+2 when FIFO and output register are empty.
// Backpressure: m_* hold while m_ready_i=0; a full FIFO drops the new byte and sets sticky ovf_o.
module uart_mc_monitor #(
    parameter int NCH        = 2,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int CLK_DIV    = 208,
    parameter int FIFO_DEPTH = 8,
    localparam int CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic [NCH-1:0]       rx_i,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic [CW-1:0]        m_chan_o,
    output logic [DATA_BITS-1:0] m_data_o,
    output logic                 m_perr_o,
    output logic                 m_ferr_o,
    output logic [NCH-1:0]       ovf_o,
    input  logic                 clr_ovf_i
);
    localparam int EW   = DATA_BITS + 2;
    localparam int CNTW = $clog2(CLK_DIV);
    localparam int BITW = $clog2(DATA_BITS);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_PAR   = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;
    localparam logic [2:0] S_BRK   = 3'd5;

    localparam logic [CNTW-1:0] HALF_RLD = CNTW'(CLK_DIV / 2 - 1);
    localparam logic [CNTW-1:0] FULL_RLD = CNTW'(CLK_DIV - 1);
    localparam logic [BITW-1:0] LAST_BIT = BITW'(DATA_BITS - 1);

    logic [NCH-1:0] push_vld;
    logic [NCH-1:0] pop_rdy;
    logic [NCH-1:0] fifo_full;
    logic [NCH-1:0] fifo_empty;
    logic [EW-1:0]  push_dat [NCH];
    logic [EW-1:0]  fifo_dat [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic                 sync1;
        logic                 rx_s;
        logic                 rx_d;
        logic [2:0]           state;
        logic [CNTW-1:0]      cnt;
        logic [BITW-1:0]      bit_idx;
        logic [DATA_BITS-1:0] shreg;
        logic                 perr;
        logic                 tick;

        assign tick = (cnt == '0);

        always_ff @(posedge clk_i) begin
            if (!rst_n_i) begin
                sync1   <= 1'b1;
                rx_s    <= 1'b1;
                rx_d    <= 1'b1;
                state   <= S_IDLE;
                cnt     <= '0;
                bit_idx <= '0;
                shreg   <= '0;
                perr    <= 1'b0;
            end else begin
                sync1 <= rx_i[c];
                rx_s  <= sync1;
                rx_d  <= rx_s;
                if (!en_i) begin
                    state <= S_IDLE;
                end else begin
                    case (state)
                        S_IDLE: begin
                            if (rx_d && !rx_s) begin
                                state <= S_START;
                                cnt   <= HALF_RLD;
                            end
                        end
                        S_START: begin
                            if (!tick) begin
                                cnt <= cnt - 1'b1;
                            end else if (rx_s) begin
                                state <= S_IDLE;
                            end else begin
                                state   <= S_DATA;
                                cnt     <= FULL_RLD;
                                bit_idx <= '0;
                                perr    <= 1'b0;
                            end
                        end
                        S_DATA: begin
                            if (!tick) begin
                                cnt <= cnt - 1'b1;
                            end else begin
                                shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                                cnt   <= FULL_RLD;
                                if (bit_idx == LAST_BIT) begin
                                    state <= (PARITY != 0) ? S_PAR : S_STOP;
                                end else begin
                                    bit_idx <= bit_idx + 1'b1;
                                end
                            end
                        end
                        S_PAR: begin
                            if (!tick) begin
                                cnt <= cnt - 1'b1;
                            end else begin
                                // odd parity expects an odd count of ones over data plus parity bit
                                perr  <= (PARITY == 1) ? ~(^shreg ^ rx_s) : (^shreg ^ rx_s);
                                state <= S_STOP;
                                cnt   <= FULL_RLD;
                            end
                        end
                        S_STOP: begin
                            if (!tick) begin
                                cnt <= cnt - 1'b1;
                            end else begin
                                state <= rx_s ? S_IDLE : S_BRK;
                            end
                        end
                        S_BRK: begin
                            if (rx_s) state <= S_IDLE;
                        end
                        default: state <= S_IDLE;
                    endcase
                end
            end
        end

        assign push_vld[c] = en_i && (state == S_STOP) && tick;
        assign push_dat[c] = {perr, ~rx_s, shreg};

        uart_mc_fifo #(
            .W     (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk_i    (clk_i),
            .rst_n_i  (rst_n_i),
            .push_vld (push_vld[c]),
            .push_dat (push_dat[c]),
            .pop_rdy  (pop_rdy[c]),
            .pop_dat  (fifo_dat[c]),
            .full     (fifo_full[c]),
            .empty    (fifo_empty[c])
        );
    end

    logic [CW-1:0] rr_ptr;
    logic          gnt_vld;
    logic [CW-1:0] gnt_idx;
    logic          out_load;

    assign out_load = !m_valid_o || m_ready_i;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!gnt_vld && !fifo_empty[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = CW'(idx);
            end
        end
    end

    always_comb begin
        pop_rdy = '0;
        if (out_load && gnt_vld) pop_rdy[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            m_valid_o <= 1'b0;
            m_chan_o  <= '0;
            m_data_o  <= '0;
            m_perr_o  <= 1'b0;
            m_ferr_o  <= 1'b0;
            rr_ptr    <= '0;
            ovf_o     <= '0;
        end else begin
            if (out_load) begin
                m_valid_o <= gnt_vld;
                if (gnt_vld) begin
                    m_chan_o                         <= gnt_idx;
                    {m_perr_o, m_ferr_o, m_data_o}   <= fifo_dat[gnt_idx];
                    rr_ptr <= (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + 1'b1;
                end
            end
            // a fresh overflow outranks a clear in the same cycle
            ovf_o <= (ovf_o & ~{NCH{clr_ovf_i}}) | (push_vld & fifo_full & ~pop_rdy);
        end
    end
endmodule

// Generic show-ahead FIFO; push while full is accepted only if a pop happens in the same cycle.
// Latency: written entry is visible on pop_dat the cycle after the push.
// Backpressure: full is reported to the writer; a refused push is simply ignored here.
module uart_mc_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_rdy && !empty;
    assign do_push = push_vld && (!full || do_pop);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// File: tb/tb_uart_mc_monitor.sv
// Bench for uart_mc_monitor: 8N1 instance for most checks, even-parity instance for parity checks.
module tb_uart_mc_monitor;
    localparam int CLK_DIV = 16;

    typedef struct {
        int ch;
        int data;
        int perr;
        int ferr;
        int cyc;
    } beat_t;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       stop;
        int         exp_chan;
        int         exp_data;
        int         exp_ferr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       m_ready;
    logic       m_ready1;
    logic       clr_ovf;
    logic [1:0] rx0;
    logic [1:0] rx1;

    logic       vld0, perr0, ferr0;
    logic [0:0] chan0;
    logic [7:0] data0;
    logic [1:0] ovf0;
    logic       vld1, perr1, ferr1;
    logic [0:0] chan1;
    logic [7:0] data1;
    logic [1:0] ovf1;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    cyc = 0;
    int    t_start = 0;
    bit    rand_mode = 0;
    beat_t got0[$];
    beat_t got1[$];
    beat_t exp_q[$];
    vec_t  vt[6];

    always #5 clk = ~clk;

    uart_mc_monitor #(
        .NCH(2), .DATA_BITS(8), .PARITY(0), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .rx_i(rx0),
        .m_valid_o(vld0), .m_ready_i(m_ready), .m_chan_o(chan0), .m_data_o(data0),
        .m_perr_o(perr0), .m_ferr_o(ferr0), .ovf_o(ovf0), .clr_ovf_i(clr_ovf)
    );

    uart_mc_monitor #(
        .NCH(2), .DATA_BITS(8), .PARITY(2), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(4)
    ) dut_p (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .rx_i(rx1),
        .m_valid_o(vld1), .m_ready_i(m_ready1), .m_chan_o(chan1), .m_data_o(data1),
        .m_perr_o(perr1), .m_ferr_o(ferr1), .ovf_o(ovf1), .clr_ovf_i(clr_ovf)
    );

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Accepted beats; valid/ready only change at posedge, so the negedge view matches the handshake.
    initial forever begin
        beat_t b;
        @(negedge clk);
        if (vld0 && m_ready) begin
            b.ch = int'(chan0); b.data = int'(data0); b.perr = int'(perr0);
            b.ferr = int'(ferr0); b.cyc = cyc;
            got0.push_back(b);
        end
        if (vld1 && m_ready1) begin
            b.ch = int'(chan1); b.data = int'(data1); b.perr = int'(perr1);
            b.ferr = int'(ferr1); b.cyc = cyc;
            got1.push_back(b);
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_mode) m_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        m_ready = v;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Line bits, LSB transmitted first: start, data, optional parity, stop, then idle high.
    function automatic logic [11:0] mkframe(input logic [7:0] d, input logic par_en,
                                            input logic p, input logic stop);
        if (par_en) return {1'b1, stop, p, d, 1'b0};
        return {2'b11, stop, d, 1'b0};
    endfunction

    task automatic drive(input int sel, input logic [1:0] mask, input logic [11:0] f0,
                         input logic [11:0] f1, input int nb);
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i == 0) t_start = cyc;
            if (sel == 0) begin
                if (mask[0]) rx0[0] = f0[i];
                if (mask[1]) rx0[1] = f1[i];
            end else begin
                if (mask[0]) rx1[0] = f0[i];
                if (mask[1]) rx1[1] = f1[i];
            end
            repeat (CLK_DIV - 1) @(negedge clk);
        end
    endtask

    task automatic line_high(input int sel);
        if (sel == 0) rx0 = 2'b11;
        else          rx1 = 2'b11;
    endtask

    task automatic send(input int sel, input int ch, input logic [7:0] d,
                        input logic par_en, input logic p, input logic stop);
        logic [11:0] f;
        f = mkframe(d, par_en, p, stop);
        drive(sel, (ch == 0) ? 2'b01 : 2'b10, f, f, par_en ? 11 : 10);
        line_high(sel);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_n(input int sel, input int n, input int budget, input string name);
        int k;
        int sz;
        k  = 0;
        sz = (sel == 0) ? got0.size() : got1.size();
        while (sz < n && k < budget) begin
            @(negedge clk);
            k++;
            sz = (sel == 0) ? got0.size() : got1.size();
        end
        chk(name, sz, n);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, int'(vld0), 0);
        chk({tag, "_chan"},  int'(chan0), 0);
        chk({tag, "_data"},  int'(data0), 0);
        chk({tag, "_perr"},  int'(perr0), 0);
        chk({tag, "_ferr"},  int'(ferr0), 0);
        chk({tag, "_ovf"},   int'(ovf0), 0);
    endtask

    initial begin
        beat_t b;
        int    bad_stable;
        int    ones;

        vt[0] = '{0, 8'h00, 1'b1, 0, 'h00, 0};
        vt[1] = '{1, 8'hFF, 1'b1, 1, 'hFF, 0};
        vt[2] = '{0, 8'h80, 1'b1, 0, 'h80, 0};
        vt[3] = '{1, 8'h01, 1'b0, 1, 'h01, 1};
        vt[4] = '{1, 8'h5A, 1'b1, 1, 'h5A, 0};
        vt[5] = '{0, 8'hC3, 1'b0, 0, 'hC3, 1};

        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; m_ready1 = 1'b1; clr_ovf = 1'b0;
        rx0 = 2'b11; rx1 = 2'b11;
        repeat (4) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 0xA5 on ch0, latency from start-bit edge to valid
        got0.delete();
        send(0, 0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_n(0, 1, 60, "a5_count");
        if (got0.size() >= 1) begin
            b = got0[0];
            chk("a5_chan", b.ch, 0);
            chk("a5_data", b.data, 'hA5);
            chk("a5_perr", b.perr, 0);
            chk("a5_ferr", b.ferr, 0);
            chk("a5_latency", b.cyc - t_start, 156);
        end

        // even parity on ch1 of the parity instance
        got1.delete();
        send(1, 1, 8'h3C, 1'b1, 1'b1, 1'b1);
        send(1, 1, 8'h3C, 1'b1, 1'b0, 1'b1);
        send(1, 1, 8'h07, 1'b1, 1'b1, 1'b1);
        send(1, 0, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_n(1, 4, 60, "par_count");
        if (got1.size() >= 4) begin
            chk("par_3c_p1_data", got1[0].data, 'h3C);
            chk("par_3c_p1_chan", got1[0].ch, 1);
            chk("par_3c_p1_perr", got1[0].perr, 1);
            chk("par_3c_p0_perr", got1[1].perr, 0);
            chk("par_07_p1_perr", got1[2].perr, 0);
            chk("par_07_p0_perr", got1[3].perr, 1);
            chk("par_07_p0_chan", got1[3].ch, 0);
            chk("par_07_p0_ferr", got1[3].ferr, 0);
        end

        foreach (vt[i]) begin
            got0.delete();
            send(0, vt[i].ch, vt[i].data, 1'b0, 1'b0, vt[i].stop);
            wait_n(0, 1, 60, $sformatf("vec%0d_count", i));
            if (got0.size() >= 1) begin
                chk($sformatf("vec%0d_chan", i), got0[0].ch, vt[i].exp_chan);
                chk($sformatf("vec%0d_data", i), got0[0].data, vt[i].exp_data);
                chk($sformatf("vec%0d_ferr", i), got0[0].ferr, vt[i].exp_ferr);
                chk($sformatf("vec%0d_perr", i), got0[0].perr, 0);
            end
        end

        // framing error with a held break, then a clean frame
        got0.delete();
        drive(0, 2'b01, mkframe(8'h55, 1'b0, 1'b0, 1'b0), 12'h0, 10);
        repeat (40) @(negedge clk);
        rx0[0] = 1'b1;
        repeat (200) @(negedge clk);
        chk("brk_count", got0.size(), 1);
        if (got0.size() >= 1) begin
            chk("brk_data", got0[0].data, 'h55);
            chk("brk_ferr", got0[0].ferr, 1);
        end
        send(0, 0, 8'h12, 1'b0, 1'b0, 1'b1);
        wait_n(0, 2, 60, "after_brk_count");
        if (got0.size() >= 2) begin
            chk("after_brk_data", got0[1].data, 'h12);
            chk("after_brk_ferr", got0[1].ferr, 0);
        end

        // simultaneous frames on both channels under a stall; arbiter starts at ch0 after reset
        apply_reset();
        set_ready(1'b0);
        got0.delete();
        drive(0, 2'b11, mkframe(8'h11, 1'b0, 1'b0, 1'b1), mkframe(8'h22, 1'b0, 1'b0, 1'b1), 10);
        line_high(0);
        repeat (2) @(negedge clk);
        bad_stable = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(vld0 === 1'b1 && chan0 === 1'b0 && data0 === 8'h11)) bad_stable++;
        end
        chk("stall_stable_cycles_bad", bad_stable, 0);
        chk("stall_none_taken", got0.size(), 0);
        set_ready(1'b1);
        wait_n(0, 2, 20, "stall_count");
        if (got0.size() >= 2) begin
            chk("stall_first_chan", got0[0].ch, 0);
            chk("stall_first_data", got0[0].data, 'h11);
            chk("stall_second_chan", got0[1].ch, 1);
            chk("stall_second_data", got0[1].data, 'h22);
        end

        // overflow: output register plus 4 FIFO entries hold 5 bytes, the 6th is dropped
        set_ready(1'b0);
        got0.delete();
        for (int k = 1; k <= 6; k++) send(0, 0, 8'(k), 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ovf_set", int'(ovf0), 1);
        set_ready(1'b1);
        wait_n(0, 5, 60, "ovf_drain_count");
        repeat (300) @(negedge clk);
        chk("ovf_drain_total", got0.size(), 5);
        for (int k = 0; k < 5 && k < got0.size(); k++)
            chk($sformatf("ovf_drain%0d_data", k), got0[k].data, k + 1);
        chk("ovf_sticky", int'(ovf0), 1);
        @(negedge clk); clr_ovf = 1'b1;
        @(negedge clk); clr_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", int'(ovf0), 0);

        // 4-cycle glitch on ch1 must not start a frame
        got0.delete();
        @(negedge clk); rx0[1] = 1'b0;
        repeat (4) @(negedge clk); rx0[1] = 1'b1;
        repeat (300) @(negedge clk);
        chk("glitch_none", got0.size(), 0);

        // en_i dropped mid-frame (all-zero data keeps the line low, so no new edge appears)
        @(negedge clk); rx0[0] = 1'b0;
        repeat (50) @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk); en = 1'b1;
        repeat (100) @(negedge clk); rx0[0] = 1'b1;
        repeat (300) @(negedge clk);
        chk("en_abort_none", got0.size(), 0);

        // reset mid-frame
        @(negedge clk); rx0[0] = 1'b0;
        repeat (60) @(negedge clk);
        rst_n = 1'b0; rx0[0] = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_vals("midrst");
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("midrst_none", got0.size(), 0);

        // randomized serial traffic against a frame-level expectation queue
        got0.delete();
        exp_q.delete();
        rand_mode = 1;
        for (int n = 0; n < 30; n++) begin
            int         ch;
            logic [7:0] d;
            logic       stop;
            ch   = $urandom_range(0, 1);
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            b.ch = ch; b.data = int'(d); b.perr = 0; b.ferr = stop ? 0 : 1; b.cyc = 0;
            exp_q.push_back(b);
            send(0, ch, d, 1'b0, 1'b0, stop);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        rand_mode = 0;
        set_ready(1'b1);
        wait_n(0, exp_q.size(), 200, "rand_count");
        repeat (50) @(negedge clk);
        chk("rand_total", got0.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got0.size(); i++) begin
            chk($sformatf("rand%0d_chan", i), got0[i].ch, exp_q[i].ch);
            chk($sformatf("rand%0d_data", i), got0[i].data, exp_q[i].data);
            chk($sformatf("rand%0d_ferr", i), got0[i].ferr, exp_q[i].ferr);
        end
        ones = 0;
        foreach (got0[i]) ones += got0[i].perr;
        chk("rand_perr_total", ones, 0);
        chk("rand_ovf", int'(ovf0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
